// File: rtl/life_keys_if.sv
// Key interface between the board pins and the life core.
// The producer (life_keys) takes raw buttons in and drives the strobes out.
interface life_keys_if;
    logic [5:0] btn_raw;
    logic       key_nxt;
    logic       key_flip;
    logic       key_down;
    logic       key_up;
    logic       key_left;
    logic       key_right;

    modport master (
        input  btn_raw,
        output key_nxt, key_flip, key_down, key_up, key_left, key_right
    );

    modport slave (
        output btn_raw,
        input  key_nxt, key_flip, key_down, key_up, key_left, key_right
    );
endinterface

// File: rtl/life_keys.sv
// Six independent button channels: synchronizer, debounce filter,
// press edge detector and auto-repeat FSM, each producing a one-cycle strobe.
module life_keys #(
    parameter int unsigned CNT_W       = 25,
    parameter int unsigned DEB_CYCLES  = 500000,
    parameter int unsigned REP_DELAY   = 25000000,
    parameter int unsigned REP_RATE    = 6250000,
    parameter logic [5:0]  REPEAT_MASK = 6'b111101
) (
    input  logic            clk,
    input  logic            rst,
    life_keys_if.master     bus
);

    localparam int unsigned N_CH = 6;
    localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] DLY_MAX  = CNT_W'(REP_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_MAX = CNT_W'(REP_RATE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_REPEAT = 2'd2
    } state_t;

    logic [N_CH-1:0] w_keys;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        logic             r_s1;
        logic             r_s2;
        logic             r_stable;
        logic [CNT_W-1:0] r_dcnt;
        logic [CNT_W-1:0] r_rcnt;
        logic             r_key;
        state_t           r_state;

        logic w_deb_done;
        logic w_stable_nxt;
        logic w_rise;
        logic w_fall;

        // Edges are taken on the value stable is about to load, so the strobe
        // is registered on the same edge that stable changes.
        assign w_deb_done   = (r_s2 != r_stable) && (r_dcnt == DEB_MAX);
        assign w_stable_nxt = w_deb_done ? r_s2 : r_stable;
        assign w_rise       = w_stable_nxt & ~r_stable;
        assign w_fall       = ~w_stable_nxt & r_stable;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_s1     <= 1'b0;
                r_s2     <= 1'b0;
                r_stable <= 1'b0;
                r_dcnt   <= '0;
                r_rcnt   <= '0;
                r_key    <= 1'b0;
                r_state  <= ST_IDLE;
            end else begin
                r_s1     <= bus.btn_raw[g];
                r_s2     <= r_s1;
                r_stable <= w_stable_nxt;

                if ((r_s2 == r_stable) || w_deb_done) begin
                    r_dcnt <= '0;
                end else begin
                    r_dcnt <= r_dcnt + CNT_W'(1);
                end

                r_key <= 1'b0;
                // Release has priority over any strobe on the same edge.
                if (w_fall) begin
                    r_state <= ST_IDLE;
                    r_rcnt  <= '0;
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (w_rise) begin
                                r_key   <= 1'b1;
                                r_rcnt  <= '0;
                                r_state <= ST_HOLD;
                            end
                        end
                        ST_HOLD: begin
                            // With repeat masked off, HOLD acts as a silent wait: counter frozen.
                            if (REPEAT_MASK[g]) begin
                                if (r_rcnt == DLY_MAX) begin
                                    r_key   <= 1'b1;
                                    r_rcnt  <= '0;
                                    r_state <= ST_REPEAT;
                                end else begin
                                    r_rcnt <= r_rcnt + CNT_W'(1);
                                end
                            end
                        end
                        ST_REPEAT: begin
                            if (r_rcnt == RATE_MAX) begin
                                r_key  <= 1'b1;
                                r_rcnt <= '0;
                            end else begin
                                r_rcnt <= r_rcnt + CNT_W'(1);
                            end
                        end
                        default: begin
                            r_state <= ST_IDLE;
                            r_rcnt  <= '0;
                        end
                    endcase
                end
            end
        end

        assign w_keys[g] = r_key;
    end

    assign bus.key_nxt   = w_keys[0];
    assign bus.key_flip  = w_keys[1];
    assign bus.key_down  = w_keys[2];
    assign bus.key_up    = w_keys[3];
    assign bus.key_left  = w_keys[4];
    assign bus.key_right = w_keys[5];

endmodule

// File: tb/tb_life_keys.sv
// Bench for life_keys: a sample-window/elapsed-time model checked every cycle,
// plus literal strobe-edge lists for each directed scenario.
module tb_life_keys;

    localparam int CNT_W = 4;
    localparam int DEB   = 4;
    localparam int RDLY  = 10;
    localparam int RRATE = 3;
    localparam logic [5:0] MASK = 6'b111101;

    logic clk = 1'b0;
    logic rst = 1'b1;

    life_keys_if kif();

    life_keys #(
        .CNT_W      (CNT_W),
        .DEB_CYCLES (DEB),
        .REP_DELAY  (RDLY),
        .REP_RATE   (RRATE),
        .REPEAT_MASK(MASK)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(kif)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;

    logic [5:0] w_dut;
    assign w_dut = {kif.key_right, kif.key_left, kif.key_up,
                    kif.key_down, kif.key_flip, kif.key_nxt};

    // Model state: raw samples of the last 6 edges, accepted level, press time.
    logic [5:0] m_hist [6];
    logic [5:0] m_stable;
    logic [5:0] m_pressed;
    logic [5:0] m_exp;
    int         m_press_e [6];
    int         obs [6][$];
    int         exp_q [$];

    // A level is accepted once the synchronised input (raw sampled two edges
    // earlier) has disagreed with the accepted level for DEB consecutive edges.
    always @(posedge clk) begin
        int         e;
        logic       r;
        logic [5:0] b;
        bit         flip;
        int         t;
        e = edge_n;
        edge_n++;
        r = rst;
        b = kif.btn_raw;
        if (r) begin
            for (int k = 0; k < 6; k++) m_hist[k] = '0;
            m_stable  = '0;
            m_pressed = '0;
            m_exp     = '0;
        end else begin
            for (int k = 5; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = b;
            m_exp = '0;
            for (int ch = 0; ch < 6; ch++) begin
                flip = 1'b1;
                for (int k = 2; k < 2 + DEB; k++)
                    if (m_hist[k][ch] == m_stable[ch]) flip = 1'b0;
                if (flip && !m_stable[ch]) begin
                    m_stable[ch]  = 1'b1;
                    m_pressed[ch] = 1'b1;
                    m_press_e[ch] = e;
                    m_exp[ch]     = 1'b1;
                end else if (flip) begin
                    m_stable[ch]  = 1'b0;
                    m_pressed[ch] = 1'b0;
                end else if (m_pressed[ch] && MASK[ch]) begin
                    t = e - m_press_e[ch];
                    if (t == RDLY || (t > RDLY && (t - RDLY) % RRATE == 0))
                        m_exp[ch] = 1'b1;
                end
            end
        end
        #1;
        checks++;
        if (w_dut !== m_exp) begin
            errors++;
            $display("FAIL model edge=%0d got=%b want=%b", e, w_dut, m_exp);
        end
        for (int ch = 0; ch < 6; ch++)
            if (w_dut[ch] === 1'b1) obs[ch].push_back(e);
    end

    task automatic clear_obs();
        for (int ch = 0; ch < 6; ch++) obs[ch].delete();
    endtask

    task automatic check_list(input int ch, input int e0, input string name);
        checks++;
        if (obs[ch].size() != exp_q.size()) begin
            errors++;
            $display("FAIL %s ch%0d strobe count got %0d want %0d",
                     name, ch, obs[ch].size(), exp_q.size());
        end else begin
            for (int i = 0; i < exp_q.size(); i++) begin
                checks++;
                if (obs[ch][i] - e0 != exp_q[i]) begin
                    errors++;
                    $display("FAIL %s ch%0d strobe %0d at edge got %0d want %0d",
                             name, ch, i, obs[ch][i] - e0, exp_q[i]);
                end
            end
        end
    endtask

    task automatic check_quiet(input int skip_a, input int skip_b, input int e0,
                               input string name);
        exp_q.delete();
        for (int ch = 0; ch < 6; ch++)
            if (ch != skip_a && ch != skip_b) check_list(ch, e0, name);
    endtask

    initial begin
        int e0;
        kif.btn_raw = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (w_dut !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%b want=000000", w_dut);
        end
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Clean press on nxt, held 8 cycles.
        clear_obs();
        e0 = edge_n;
        kif.btn_raw = 6'b000001;
        repeat (8) @(negedge clk);
        kif.btn_raw = '0;
        repeat (20) @(negedge clk);
        exp_q = '{5};
        check_list(0, e0, "clean_press");
        check_quiet(0, 0, e0, "clean_press_others");

        // Glitch and chatter on up: every level shorter than the debounce window.
        clear_obs();
        e0 = edge_n;
        kif.btn_raw = 6'b001000; repeat (3) @(negedge clk);
        kif.btn_raw = 6'b000000; repeat (2) @(negedge clk);
        kif.btn_raw = 6'b001000; repeat (3) @(negedge clk);
        kif.btn_raw = 6'b000000; repeat (1) @(negedge clk);
        kif.btn_raw = 6'b001000; repeat (2) @(negedge clk);
        kif.btn_raw = 6'b000000; repeat (20) @(negedge clk);
        check_quiet(-1, -1, e0, "glitch");

        // Auto-repeat on up, held for edges 0..29.
        clear_obs();
        e0 = edge_n;
        kif.btn_raw = 6'b001000;
        repeat (30) @(negedge clk);
        kif.btn_raw = '0;
        repeat (25) @(negedge clk);
        exp_q = '{5, 15, 18, 21, 24, 27, 30, 33};
        check_list(3, e0, "auto_repeat");
        check_quiet(3, 3, e0, "auto_repeat_others");

        // Flip has repeat masked off.
        clear_obs();
        e0 = edge_n;
        kif.btn_raw = 6'b000010;
        repeat (30) @(negedge clk);
        kif.btn_raw = '0;
        repeat (20) @(negedge clk);
        exp_q = '{5};
        check_list(1, e0, "repeat_masked");
        check_quiet(1, 1, e0, "repeat_masked_others");

        // Left and right pressed together, held for edges 0..13.
        clear_obs();
        e0 = edge_n;
        kif.btn_raw = 6'b110000;
        repeat (14) @(negedge clk);
        kif.btn_raw = '0;
        repeat (20) @(negedge clk);
        exp_q = '{5, 15, 18};
        check_list(4, e0, "simul_left");
        check_list(5, e0, "simul_right");
        check_quiet(4, 5, e0, "simul_others");

        // Reset pulse at edges 20,21 while down is repeating; R = 22.
        clear_obs();
        e0 = edge_n;
        kif.btn_raw = 6'b000100;
        repeat (20) @(negedge clk);
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            checks++;
            if (w_dut !== 6'b0) begin
                errors++;
                $display("FAIL reset_mid got=%b want=000000", w_dut);
            end
        end
        rst = 1'b0;
        repeat (18) @(negedge clk);
        kif.btn_raw = '0;
        repeat (20) @(negedge clk);
        exp_q = '{5, 15, 18, 27, 37, 40, 43};
        check_list(2, e0, "reset_mid_repeat");
        check_quiet(2, 2, e0, "reset_mid_others");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/life_keys.md
# life_keys

Debounces and conditions the six raw push-button inputs of the Life board and produces the single-cycle key strobes that the `life` top level consumes: `key_nxt`, `key_flip`, `key_down`, `key_up`, `key_left` and `key_right`. It is the producer side of the key interface. Each channel is independent and runs through a two-flop synchronizer, a debounce filter, a press edge detector and an optional auto-repeat state machine. The block sits between the board pins and `life`, in the same clock domain.

## Interface
- `CNT_W`, 25: width of the debounce and repeat counters.
- `DEB_CYCLES`, 500000: cycles an input must remain stable before it is accepted. Range 2..2^CNT_W-1.
- `REP_DELAY`, 25000000: cycles from the initial press strobe to the first repeat strobe. Range 2..2^CNT_W-1.
- `REP_RATE`, 6250000: cycles between successive repeat strobes. Range 2..2^CNT_W-1.
- `REPEAT_MASK`, 6'b111101: per-channel auto-repeat enable. Bit order is 0 nxt, 1 flip, 2 down, 3 up, 4 left, 5 right. Flip does not repeat by default.
- `clk`  in  1  system clock. This is the block's only clock.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_raw`  in  6  raw buttons, asynchronous, active-high. Bit order as for `REPEAT_MASK`.
- `key_nxt`  out  1  one-cycle strobe.
- `key_flip`  out  1  one-cycle strobe.
- `key_down`  out  1  one-cycle strobe.
- `key_up`  out  1  one-cycle strobe.
- `key_left`  out  1  one-cycle strobe.
- `key_right`  out  1  one-cycle strobe.

## Operation
Each channel is an identical slice with the following stages.

- **Synchronizer.** `btn_raw[i]` passes through `s1` and then `s2`, one flop each.
- **Debounce.**
  - The slice holds a `stable` bit and a counter `dcnt`.
  - `s2 == stable`: `dcnt` is cleared to 0.
  - `s2 != stable` and `dcnt == DEB_CYCLES-1`: `stable` takes `s2` and `dcnt` is cleared to 0.
  - `s2 != stable`, any other count: `dcnt` increments.
  - A mismatch shorter than `DEB_CYCLES` cycles leaves `stable` unchanged.
- **Repeat FSM.** Three states, IDLE, HOLD and REPEAT, with counter `rcnt`.
  - **IDLE:** on the edge where `stable` goes 0→1:
    - strobe;
    - clear `rcnt`;
    - go to HOLD if `REPEAT_MASK[i]` is set, otherwise go to WAIT.
  - **WAIT:** this is HOLD with repeat disabled; it never strobes. WAIT is encoded as HOLD with the counter frozen, so the FSM still has three states.
  - **HOLD:** `rcnt` increments each cycle. At `rcnt == REP_DELAY-1`:
    - strobe;
    - clear `rcnt`;
    - go to REPEAT.
  - **REPEAT:** at `rcnt == REP_RATE-1`:
    - strobe;
    - clear `rcnt`;
    - stay in REPEAT.
  - **Any state:** when `stable` goes 1→0, go to IDLE and clear `rcnt`. A release never strobes. If release and a strobe condition fall on the same edge, the release wins.
- **Strobe outputs.** The `key_*` outputs are registered. Each is high for exactly one cycle per strobe event.
- **Channel independence.** Channels share no state. Simultaneous presses on different channels strobe in the same cycle.

## Timing
**Reset**
- `rst` high at an edge clears the following: `s1`, `s2`, `stable`, `dcnt`, `rcnt`, FSM state (to IDLE) and all `key_*` outputs.
- All outputs are 0 from the first edge with `rst` high and stay 0 while `rst` remains high.
- Reset asserted mid-repeat: the strobe stops immediately and no further strobe occurs while `rst` is high.
- A button still held when reset is released counts as a new press, because `stable` was reset to 0.

**Press latency**
- Edge 0 is the first edge that samples `btn_raw` high into `s1`.
- `stable` rises and the strobe is high during the cycle after edge `DEB_CYCLES+1`.

**Repeat and release**
- First repeat strobe: `REP_DELAY` cycles after the press strobe.
- Subsequent repeat strobes: every `REP_RATE` cycles.
- Release latency mirrors press latency: `stable` falls at edge `DEB_CYCLES+1`, counted from the first edge that samples `btn_raw` low.

**Counter widths**
- Counters are `CNT_W` bits and never overflow within the legal parameter ranges.
- The compare values are `DEB_CYCLES-1`, `REP_DELAY-1` and `REP_RATE-1`, each truncated to `CNT_W` bits.

## Test plan
All scenarios use `CNT_W=4`, `DEB_CYCLES=4`, `REP_DELAY=10`, `REP_RATE=3` and the default mask. "Strobe at edge N" means the output is high during the cycle after edge N.

- **Clean press:** `btn_raw[0]` goes high before edge 0 and is held for 8 cycles, then goes low → `key_nxt` strobes once, at edge 5 → all other outputs stay 0.
- **Glitch rejection:** `btn_raw[3]` is high for 3 cycles only → no strobe and `stable` stays 0 → a subsequent low-high-low-high chatter with each level shorter than 4 cycles also produces no strobe.
- **Auto-repeat:** `btn_raw[3]` is high for edges 0..29, then low → `key_up` strobes at edges 5, 15, 18, 21, 24, 27, 30 and 33 (8 strobes) → no strobe at or after edge 35.
- **Repeat masked:** `btn_raw[1]` is held for 30 cycles → exactly one `key_flip` strobe, at edge 5.
- **Simultaneous press:** `btn_raw[4]` and `btn_raw[5]` rise in the same cycle → `key_left` and `key_right` strobe in the same cycle (edge 5) → with both held, their repeat strobes coincide at edges 15 and 18.
- **Reset mid-repeat:** `btn_raw[2]` is held and `rst` is pulsed high for 2 cycles at edge 20 → all outputs are 0 while `rst` is high → let edge R be the first edge with `rst` low; `key_down` strobes at R+5 → repeats resume at R+15.
